// File: rtl/blakley_modmul.sv
// blakley_modmul: radix-2 Blakley modular multiplier, result = (a * b) mod n.
// Start/done handshake. The multiplier operand is scanned MSB-first with one
// ADD and one REDUCE cycle per bit.
// Optional macro BLAKLEY_EARLY_TERM_EN: the scan starts at the top set bit of a,
// and a == 0 finishes immediately.
module blakley_modmul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned RW = WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_REDUCE, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_lat, b_lat, n_lat;
  logic [WIDTH-1:0] r;
  logic [RW-1:0]    r2;
  logic [IW-1:0]    idx;

  logic             range_err_c;
  logic             skip_c;
  logic [IW-1:0]    start_idx_c;
  logic [RW-1:0]    addend_c;
  logic [RW-1:0]    n1_c, n2_c;
  logic [WIDTH-1:0] red_c;
  logic             busy_nxt, done_nxt;

  assign range_err_c = (n == '0) || (a >= n) || (b >= n);

`ifdef BLAKLEY_EARLY_TERM_EN
  // Start index is the top set bit of a. R stays 0 through the leading zero bits.
  always_comb begin
    start_idx_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (a[i]) start_idx_c = IW'(i);
    end
  end
  assign skip_c = (a == '0);
`else
  assign start_idx_c = IW'(WIDTH - 1);
  assign skip_c      = 1'b0;
`endif

  assign addend_c = a_lat[idx] ? RW'(b_lat) : '0;
  assign n1_c     = RW'(n_lat);
  assign n2_c     = {1'b0, n_lat, 1'b0};

  // Fold R2 (< 3n) back below n with at most one subtract of n or 2n.
  always_comb begin
    if (r2 >= n2_c) begin
      red_c = WIDTH'(r2 - n2_c);
    end else if (r2 >= n1_c) begin
      red_c = WIDTH'(r2 - n1_c);
    end else begin
      red_c = WIDTH'(r2);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset_l) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (range_err_c || skip_c) ? S_DONE : S_ADD;
      S_ADD:    state_nxt = S_REDUCE;
      S_REDUCE: state_nxt = (idx == '0) ? S_DONE : S_ADD;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the next state, so the registered flags line up with the state.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_DONE);
  end

  // Registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset_l) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Operand latches, shift-add-reduce datapath and held result/err.
  always_ff @(posedge clk) begin
    if (reset_l) begin
      a_lat  <= '0;
      b_lat  <= '0;
      n_lat  <= '0;
      r      <= '0;
      r2     <= '0;
      idx    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_lat <= a;
            b_lat <= b;
            n_lat <= n;
            r     <= '0;
            idx   <= start_idx_c;
            if (range_err_c || skip_c) begin
              result <= '0;
              err    <= range_err_c;
            end else begin
              err    <= 1'b0;
            end
          end
        end
        S_ADD: begin
          r2 <= {1'b0, r, 1'b0} + addend_c;
        end
        S_REDUCE: begin
          r <= red_c;
          if (idx == '0) result <= red_c;
          else           idx    <= idx - IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/blakley_modmul.md
Name: blakley_modmul

Overview:
- Parametrised radix-2 Blakley modular multiplier: result = (a * b) mod n for WIDTH-bit operands.
- Multi-cycle replacement for the fixed 5-bit blakley multiplier, with a start/done handshake, operand range checking and held result.
- Sits under the RSA modular-exponentiation controller, which issues one multiply per start pulse.

Parameters:
- WIDTH, 32, operand, modulus and result width in bits; legal range 2..4096.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_l  input  1  synchronous, active-high reset (asserted = 1); sampled on clk rising edge.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplier operand; scanned MSB-first.
- b  input  WIDTH  multiplicand operand.
- n  input  WIDTH  modulus.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result and err are valid in that cycle.
- result  output  WIDTH  (a*b) mod n; held until the next accepted start.
- err  output  1  operand violation on the last request; held like result.

Behaviour:
- Reset (reset_l=1): state=IDLE, busy=0, done=0, result=0, err=0, R=0, bit counter=0. Reset mid-operation aborts immediately, with no done pulse.
- Accept: in IDLE with start=1, latch a, b and n into internal registers. Inputs are don't-care after the accept cycle. start in any other state is ignored, with no queueing.
- Range check at accept:
  - Applies when n==0, a>=n or b>=n.
  - Next state is DONE, with result=0 and err=1.
  - done therefore pulses 1 cycle after accept.
- Valid accept: R=0, idx=WIDTH-1, err=0, next state ADD.
- States:
  - IDLE.
  - ADD: R2 = (R<<1) + (a_lat[idx] ? b_lat : 0). R2 is WIDTH+2 bits wide. Next state REDUCE.
  - REDUCE: with R < n, b < n, R2 < 3n:
    - R2 >= 2n: R = R2 - 2n.
    - else R2 >= n: R = R2 - n.
    - else R = R2.
    - Compares and subtracts are unsigned at WIDTH+2 bits, and 2n is formed without overflow.
    - If idx==0, next state DONE; else idx-=1 and next state ADD.
  - DONE: done=1 for exactly this cycle, result=R[WIDTH-1:0]. Next state IDLE.
- Invariant: R < n after every REDUCE.
- busy: 1 in ADD, REDUCE and DONE; 0 in IDLE.
- Latency:
  - Valid request: start accepted in cycle 0, done high in cycle 2*WIDTH+1. The next start can be accepted in cycle 2*WIDTH+2.
  - Error request: done high in cycle 1.
- Back-to-back: start held high continuously is accepted again in the first IDLE cycle after DONE.
- Boundary cases:
  - a=0 or b=0 returns 0 with full latency.
  - n=1 is always an error, since a>=1 or b>=1 unless both are 0. a=b=0, n=1 returns 0 with err=0.

Optional Feature:
- Macro: BLAKLEY_EARLY_TERM_EN.
- Defined:
  - At accept, idx is initialised to the position of the most-significant set bit of a; the leading zero bits are skipped, since R stays 0 through them.
  - If a==0 (valid request), go straight to DONE: result=0, done in cycle 1.
  - Otherwise done is high in cycle 2*(msb+1)+1.
  - Result values are identical to the non-macro build.
- Not defined: fixed latency of 2*WIDTH+1 for all valid requests, as above.

Test Plan:
- WIDTH=5: a=7, b=9, n=13 -> result=11, err=0, done in cycle 11 after accept, busy high in cycles 1..11.
- WIDTH=5: a=12, b=12, n=13 -> result=1. WIDTH=8: a=200, b=250, n=251 -> result=51, done in cycle 17.
- WIDTH=8 error cases, each giving done in cycle 1, err=1, result=0:
  - n=0.
  - a=5, b=251, n=251.
  - a=251, b=5, n=251.
  - A following valid request clears err.
- WIDTH=8: pulse start again at cycles 3 and 10 during a valid op -> ignored, single done, result unchanged. Assert reset_l in cycle 6 -> no done pulse, all outputs 0 next cycle.
- WIDTH=8, start held high with a=3, b=4, n=7, then a=6, b=6, n=7 -> results 5 then 1. Done pulses in cycles 17 and 35; result holds 5 between them.
- With BLAKLEY_EARLY_TERM_EN, WIDTH=8:
  - a=1, b=100, n=101 -> result 100, done in cycle 3.
  - a=0 -> result 0, done in cycle 1.
  - a=128, b=2, n=200 -> result 56, done in cycle 17.
